seg7_scan_decoder: RTL
======================

# seg7_scan_decoder

Decoder at the far end of the BCD-to-7-segment path: it samples a multiplexed, active-low 7-segment display bus (segment lines plus per-digit anode selects) and recovers the BCD value of each digit. Each digit's pattern is debounced, decoded and collected into a multi-digit frame, which is delivered on a valid/ready handshake. It sits in display loop-back self-test and in external-display sniffing paths, downstream of the scan driver pins.

## Interface

Parameters:
- DIGITS, 4, number of multiplexed digits (1..8).
- STABLE_CYCLES, 16, consecutive identical synchronized samples needed before a digit is captured (2..255).

Ports:
- Clocking: one clock; reset is synchronous and active-low.
- clk  input  1  system clock.
- rst_n  input  1  synchronous active-low reset.
- seg_in  input  7  segment lines, active-low; bit6=a … bit0=g.
- an_in  input  DIGITS  anode selects, active-low, one-hot when a digit is driven.
- bcd_out  output  4*DIGITS  decoded frame; digit i occupies bits [4i+3:4i].
- digit_err  output  DIGITS  per-digit flag: the captured pattern was not a legal code.
- frame_valid  output  1  bcd_out/digit_err hold a complete frame.
- frame_ready  input  1  consumer accepts the frame when high with frame_valid.
- overrun  output  1  sticky: a digit was recaptured while a completed frame was blocked.

## Operation

- seg_in and an_in pass through a 2-flop synchronizer; all logic below uses synchronized values.
- Select check: a sample is valid only if exactly one an bit is low. Zero or multiple low bits count as blanking.
- Sampler FSM:
  - IDLE: the sample is blanking. Go to TRACK when a valid select appears, with count=0.
  - TRACK: if the {an, seg} sample equals the previous one, increment count; otherwise restart count=0, or go to IDLE on blanking. When count reaches STABLE_CYCLES-1, issue one capture and go to HELD.
  - HELD: no further captures. Go to TRACK (count=0) on any sample change, or to IDLE on blanking.
- Decode at capture (segment codes are a..g):
  - 0000001→0, 1001111→1, 0010010→2, 0000110→3, 1001100→4, 0100100→5, 0100000→6, 0001111→7, 0000000→8, 0000100→9.
  - 1111111→4'hF (blank), err=0.
  - Any other code→4'hE, err=1.
- Capture writes work_bcd[d], work_err[d] and sets seen[d]. A second capture of the same digit before frame completion overwrites it (latest wins).
- Frame completion: seen is all ones and the output slot is free (frame_valid=0, or frame_valid&&frame_ready this cycle). Then copy work to bcd_out/digit_err, set frame_valid, and clear seen.
- Blocked case: if seen is full and the slot is not free, seen stays full and work continues to accept captures. Each such capture sets overrun.
- frame_valid clears on frame_valid&&frame_ready, unless a new frame loads in the same cycle; in that case it stays high with the new data.

## Timing

- Reset values: bcd_out all 4'hF, digit_err 0, frame_valid 0, overrun 0; sampler in IDLE; seen 0; synchronizers 1s (bus idle).
- Synchronizer latency: 2 cycles.
- A pattern change at the pins at edge N produces its capture at edge N+2+STABLE_CYCLES. With a free slot, frame_valid rises at the next edge: N+STABLE_CYCLES+3 (19 by default) for the last digit.
- bcd_out/digit_err stay stable while frame_valid=1 and frame_ready=0.
- Any dwell shorter than STABLE_CYCLES samples produces no capture, and seen is unchanged.
- Reset mid-frame discards partial work and any held frame on the same edge.

## Configuration

- SEG7_DEC_DP_EN defined:
  - Adds input dp_in (active-low decimal point) to the synchronizer and to the stability comparison.
  - Adds output dp_out[DIGITS-1:0], active-high, captured and framed alongside bcd_out, reset 0.
- Undefined: neither port exists, and only the 7 segment bits are compared and decoded.

## Test plan

- Scan digits 0..3 with patterns for 1,2,3,4, each held 40 cycles, frame_ready=1 → frame_valid pulses with bcd_out=16'h4321, digit_err=0.
- Drive digit 2 with 1111110, others legal → bcd_out[11:8]=4'hE, digit_err=4'b0100. Drive 1111111 → nibble 4'hF, err=0.
- Glitch: hold a pattern for STABLE_CYCLES-1 samples, then change it → no capture. Hold for exactly STABLE_CYCLES samples → exactly one capture, frame_valid at the +3 latency.
- Hold frame_ready=0 across two full scans → first frame stays on bcd_out, overrun=1. Raise frame_ready for one cycle → second frame loads and frame_valid stays 1.
- Drive two an bits low, or all high, for 100 cycles → no captures and seen is unchanged.
- Assert rst_n=0 for one cycle after 3 of 4 digits have been captured → all outputs return to reset values, and the next full scan yields a correct frame.

Source files
------------

// File: rtl/seg7_scan_decoder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | seg7_scan_decoder: recovers BCD digit frames from a multiplexed active-  |
// | low 7-segment bus. Define SEG7_DEC_DP_EN to add decimal-point capture.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module seg7_scan_decoder #(
  parameter int DIGITS        = 4,
  parameter int STABLE_CYCLES = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [6:0]          seg_in,
  input  logic [DIGITS-1:0]   an_in,
`ifdef SEG7_DEC_DP_EN
  input  logic                dp_in,
  output logic [DIGITS-1:0]   dp_out,
`endif
  output logic [4*DIGITS-1:0] bcd_out,
  output logic [DIGITS-1:0]   digit_err,
  output logic                frame_valid,
  input  logic                frame_ready,
  output logic                overrun
);

  localparam int CW = 8;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_TRACK = 2'd1,
    S_HELD  = 2'd2
  } state_t;

`ifdef SEG7_DEC_DP_EN
  localparam int SW = DIGITS + 8;
  logic [SW-1:0] pins;
  assign pins = {an_in, seg_in, dp_in};
`else
  localparam int SW = DIGITS + 7;
  logic [SW-1:0] pins;
  assign pins = {an_in, seg_in};
`endif

  logic [SW-1:0]       sync1_q, sync1_d, sync2_q, sync2_d, prev_q, prev_d;
  state_t              state_q, state_d;
  logic [CW-1:0]       count_q, count_d;
  logic [DIGITS-1:0]   samp_sel, cap_mask;
  logic                samp_ok, samp_same, capture;
  logic [4:0]          cap_code;

  logic [DIGITS-1:0]   seen_q, seen_d;
  logic [4*DIGITS-1:0] work_bcd_q, work_bcd_d, bcd_out_q, bcd_out_d;
  logic [DIGITS-1:0]   work_err_q, work_err_d, digit_err_q, digit_err_d;
  logic                frame_valid_q, frame_valid_d, overrun_q, overrun_d;
  logic                seen_full, slot_free, load;
`ifdef SEG7_DEC_DP_EN
  logic [DIGITS-1:0]   work_dp_q, work_dp_d, dp_out_q, dp_out_d;
`endif

  // {err, bcd} for one active-low a..g pattern
  function automatic logic [4:0] decode(input logic [6:0] s);
    case (s)
      7'b0000001: decode = 5'h00;
      7'b1001111: decode = 5'h01;
      7'b0010010: decode = 5'h02;
      7'b0000110: decode = 5'h03;
      7'b1001100: decode = 5'h04;
      7'b0100100: decode = 5'h05;
      7'b0100000: decode = 5'h06;
      7'b0001111: decode = 5'h07;
      7'b0000000: decode = 5'h08;
      7'b0000100: decode = 5'h09;
      7'b1111111: decode = 5'h0F;
      default:    decode = 5'h1E;
    endcase
  endfunction

  assign samp_sel  = ~sync2_q[SW-1 -: DIGITS];
  assign samp_ok   = (samp_sel != '0) && ((samp_sel & (samp_sel - DIGITS'(1))) == '0);
  assign samp_same = (sync2_q == prev_q);
  // prev_q still holds the stable pattern on the capture cycle
  assign cap_mask  = ~prev_q[SW-1 -: DIGITS];
  assign cap_code  = decode(prev_q[SW-DIGITS-1 -: 7]);

  always_comb begin
    sync1_d = pins;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
    state_d = state_q;
    count_d = count_q;
    capture = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (samp_ok) begin
          state_d = S_TRACK;
          count_d = '0;
        end
      end
      S_TRACK: begin
        if (count_q == CW'(STABLE_CYCLES - 1)) begin
          capture = 1'b1;
          if (!samp_ok)      state_d = S_IDLE;
          else if (samp_same) state_d = S_HELD;
          else               count_d = '0;
        end else if (!samp_ok) begin
          state_d = S_IDLE;
        end else if (samp_same) begin
          count_d = count_q + CW'(1);
        end else begin
          count_d = '0;
        end
      end
      S_HELD: begin
        if (!samp_ok) begin
          state_d = S_IDLE;
        end else if (!samp_same) begin
          state_d = S_TRACK;
          count_d = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign seen_full = &seen_q;
  assign slot_free = !frame_valid_q || frame_ready;
  assign load      = seen_full && slot_free;

  always_comb begin
    seen_d        = load ? '0 : seen_q;
    work_bcd_d    = work_bcd_q;
    work_err_d    = work_err_q;
    bcd_out_d     = bcd_out_q;
    digit_err_d   = digit_err_q;
    frame_valid_d = frame_valid_q;
    overrun_d     = overrun_q;
`ifdef SEG7_DEC_DP_EN
    work_dp_d     = work_dp_q;
    dp_out_d      = dp_out_q;
`endif
    // the frame is copied from work before this cycle's capture lands
    if (load) begin
      bcd_out_d     = work_bcd_q;
      digit_err_d   = work_err_q;
      frame_valid_d = 1'b1;
`ifdef SEG7_DEC_DP_EN
      dp_out_d      = work_dp_q;
`endif
    end else if (frame_valid_q && frame_ready) begin
      frame_valid_d = 1'b0;
    end
    if (capture && seen_full && !slot_free) overrun_d = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (capture && cap_mask[i]) begin
        work_bcd_d[4*i +: 4] = cap_code[3:0];
        work_err_d[i]        = cap_code[4];
        seen_d[i]            = 1'b1;
`ifdef SEG7_DEC_DP_EN
        work_dp_d[i]         = ~prev_q[0];
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q       <= '1;
      sync2_q       <= '1;
      prev_q        <= '1;
      state_q       <= S_IDLE;
      count_q       <= '0;
      seen_q        <= '0;
      work_bcd_q    <= {DIGITS{4'hF}};
      work_err_q    <= '0;
      bcd_out_q     <= {DIGITS{4'hF}};
      digit_err_q   <= '0;
      frame_valid_q <= 1'b0;
      overrun_q     <= 1'b0;
`ifdef SEG7_DEC_DP_EN
      work_dp_q     <= '0;
      dp_out_q      <= '0;
`endif
    end else begin
      sync1_q       <= sync1_d;
      sync2_q       <= sync2_d;
      prev_q        <= prev_d;
      state_q       <= state_d;
      count_q       <= count_d;
      seen_q        <= seen_d;
      work_bcd_q    <= work_bcd_d;
      work_err_q    <= work_err_d;
      bcd_out_q     <= bcd_out_d;
      digit_err_q   <= digit_err_d;
      frame_valid_q <= frame_valid_d;
      overrun_q     <= overrun_d;
`ifdef SEG7_DEC_DP_EN
      work_dp_q     <= work_dp_d;
      dp_out_q      <= dp_out_d;
`endif
    end
  end

  assign bcd_out     = bcd_out_q;
  assign digit_err   = digit_err_q;
  assign frame_valid = frame_valid_q;
  assign overrun     = overrun_q;
`ifdef SEG7_DEC_DP_EN
  assign dp_out      = dp_out_q;
`endif

endmodule
`default_nettype wire
